// File: rtl/partial_product_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// partial_product_accumulator_pkg
// Shared widths, state encoding and constants for the partial product
// accumulation stage of the multiplier datapath.
//   ACC_W   : running accumulator width
//   PP_W    : partial product width
//   SUM_W   : adder result width (accumulator plus carry-out)
//   state_t : IDLE / ACCUM / DONE job states
//   ACC_MAX : all-ones accumulator value (saturation target)
// ---------------------------------------------------------------------------
package partial_product_accumulator_pkg;

    localparam int ACC_W = 62;
    localparam int PP_W  = 29;
    localparam int SUM_W = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

endpackage

// File: rtl/partial_product_accumulator_pp_acc_adder.sv
// ---------------------------------------------------------------------------
// pp_acc_adder
// Combinational zero-extending adder: accumulator + partial product, with
// the carry out of the accumulator MSB returned as the top sum bit.
// Ports:
//   acc : input  [ACC_W-1:0]  current accumulator value
//   pp  : input  [PP_W-1:0]   unsigned partial product
//   sum : output [SUM_W-1:0]  {carry, acc + pp}
// ---------------------------------------------------------------------------
module pp_acc_adder
    import partial_product_accumulator_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [PP_W-1:0]  pp,
    output logic [SUM_W-1:0] sum
);

    assign sum = {1'b0, acc} + {{(SUM_W-PP_W){1'b0}}, pp};

endmodule

// File: rtl/partial_product_accumulator.sv
// ---------------------------------------------------------------------------
// partial_product_accumulator
// Sequential accumulation stage of the multiplier datapath. A job captures
// init_val on start, adds NUM_TERMS unsigned partial products (one per clock
// at most, bubbles allowed) and then presents result/overflow until the
// downstream stage accepts them.
//
// Parameters:
//   NUM_TERMS : partial products per job (1..255)
//   CNT_W     : term counter width, 2**CNT_W > NUM_TERMS
//
// Ports:
//   clk       : input       rising-edge clock
//   reset     : input       asynchronous active-high reset
//   start     : input       begin a job (sampled only in IDLE)
//   init_val  : input  [62] initial accumulator value, captured with start
//   pp_valid  : input       partial product valid
//   pp_data   : input  [29] unsigned partial product
//   pp_ready  : output      partial product accepted this cycle (ACCUM)
//   out_valid : output      result available (DONE)
//   out_ready : input       downstream accepts result
//   result    : output [62] accumulated value (0 outside DONE)
//   overflow  : output      sticky carry-out of bit 61 (0 outside DONE)
//   busy      : output      high in ACCUM and DONE
//
// Build option:
//   PPA_SATURATE_EN : when defined, the accumulator saturates to all ones on
//                     the first carry-out and stays there for the job;
//                     otherwise it wraps modulo 2**62.
// ---------------------------------------------------------------------------
module partial_product_accumulator
    import partial_product_accumulator_pkg::*;
#(
    parameter int NUM_TERMS = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ACC_W-1:0] init_val,
    input  logic             pp_valid,
    input  logic [PP_W-1:0]  pp_data,
    output logic             pp_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [SUM_W-1:0] sum;
    logic             accept;

`ifdef PPA_SATURATE_EN
    // Clamp to all ones on a fresh carry or once the job has already
    // overflowed, so a saturated accumulator never wraps back down.
    function automatic logic [ACC_W-1:0] saturate(input logic [SUM_W-1:0] s,
                                                   input logic            sticky);
        return (s[ACC_W] || sticky) ? ACC_MAX : s[ACC_W-1:0];
    endfunction
`endif

    pp_acc_adder u_adder (
        .acc (acc),
        .pp  (pp_data),
        .sum (sum)
    );

    assign accept = pp_valid && pp_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        pp_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                pp_ready = 1'b1;
                busy     = 1'b1;
                // The final beat hands off to DONE on its own accept edge.
                if (pp_valid && (count == LAST_CNT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Accumulator, term counter and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if ((state == IDLE) && start) begin
            acc   <= init_val;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
`ifdef PPA_SATURATE_EN
            acc   <= saturate(sum, ovf);
`else
            acc   <= sum[ACC_W-1:0];
`endif
            ovf   <= ovf | sum[ACC_W];
            count <= count + CNT_W'(1);
        end
    end

    // Result is only exposed while the job is being handed off.
    assign result   = (state == DONE) ? acc : '0;
    assign overflow = (state == DONE) && ovf;

endmodule
